// File: rtl/nfc_host_seq.sv
// -----------------------------------------------------------------------------
// nfc_host_seq
//   Host-side command sequencer sitting directly in front of the NAND flash
//   controller. Takes one page-level request at a time:
//     read    : start controller, then stream the page buffer to the host
//     program : stream host bytes into the page buffer, then start controller
//     erase   : start controller only
//     reset   : start controller only
//   Error flags from the controller are latched into op_stat when nfc_done is
//   seen. If nfc_done never arrives, a timeout aborts the operation instead.
//
// Ports
//   CLK, RES             clock (rising edge), synchronous active-low reset
//   host_req/op/row/ack  request handshake; ack is a 1-cycle pulse in IDLE
//   wr_data/valid/ready  program byte stream (host -> page buffer)
//   rd_data/valid/ready  read byte stream (page buffer -> host)
//   op_done, op_stat     1-cycle completion pulse, {timeout,RErr,EErr,PErr}
//   BF_sel/ad/din/we/dou page-buffer host port (dou valid 1 cycle after ad)
//   RWA, nfc_cmd         row address and command to the controller
//   nfc_strt, nfc_done   controller start pulse and completion level
//   PErr, EErr, RErr     controller error flags, sampled with nfc_done
// -----------------------------------------------------------------------------
module nfc_host_seq #(
    parameter int PAGE_BYTES = 2048,
    parameter int AW         = 11,
    parameter int RW         = 16,
    parameter int TIMEOUT    = 2**20
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          host_req,
    input  logic [1:0]    host_op,
    input  logic [RW-1:0] host_row,
    output logic          host_ack,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          op_done,
    output logic [3:0]    op_stat,
    output logic          BF_sel,
    output logic [AW-1:0] BF_ad,
    output logic [7:0]    BF_din,
    output logic          BF_we,
    input  logic [7:0]    BF_dou,
    output logic [RW-1:0] RWA,
    output logic [2:0]    nfc_cmd,
    output logic          nfc_strt,
    input  logic          nfc_done,
    input  logic          PErr,
    input  logic          EErr,
    input  logic          RErr
);

    localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]   LAST_BYTE = (AW+1)'(PAGE_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_t;

    // DRAIN sub-phase: address issued -> buffer data valid -> byte offered.
    typedef enum logic [1:0] {
        RD_ADDR,
        RD_LOAD,
        RD_SHOW
    } rd_phase_t;

    function automatic logic [2:0] op_to_cmd(input logic [1:0] op);
        logic [2:0] cmd;
        cmd = 3'b001;
        case (op)
            OP_READ:  cmd = 3'b001;
            OP_PROG:  cmd = 3'b010;
            OP_ERASE: cmd = 3'b011;
            OP_RESET: cmd = 3'b100;
            default:  cmd = 3'b001;
        endcase
        return cmd;
    endfunction

    state_t        r_state;
    rd_phase_t     r_rd_phase;
    logic [1:0]    r_op;
    logic [AW:0]   r_count;
    logic [TW-1:0] r_tmo;

    logic          r_host_ack;
    logic          r_wr_ready;
    logic [7:0]    r_rd_data;
    logic          r_rd_valid;
    logic          r_op_done;
    logic [3:0]    r_op_stat;
    logic          r_bf_sel;
    logic [AW-1:0] r_bf_ad;
    logic [7:0]    r_bf_din;
    logic          r_bf_we;
    logic [RW-1:0] r_rwa;
    logic [2:0]    r_nfc_cmd;
    logic          r_nfc_strt;

    logic [AW:0]   w_count_inc;
    logic          w_last_byte;

    assign w_count_inc = r_count + 1'b1;
    assign w_last_byte = (r_count == LAST_BYTE);

    always_ff @(posedge CLK) begin
        if (!RES) begin
            r_state    <= S_IDLE;
            r_rd_phase <= RD_ADDR;
            r_op       <= '0;
            r_count    <= '0;
            r_tmo      <= '0;
            r_host_ack <= 1'b0;
            r_wr_ready <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_op_done  <= 1'b0;
            r_op_stat  <= '0;
            r_bf_sel   <= 1'b0;
            r_bf_ad    <= '0;
            r_bf_din   <= '0;
            r_bf_we    <= 1'b0;
            r_rwa      <= '0;
            r_nfc_cmd  <= '0;
            r_nfc_strt <= 1'b0;
        end else begin
            // NOTE: single-cycle pulses get a default of 0 here so every
            // state only has to say when they fire; all state updates use
            // non-blocking assignments so the order of the statements below
            // never changes what a neighbouring register sees this edge.
            r_host_ack <= 1'b0;
            r_bf_we    <= 1'b0;
            r_nfc_strt <= 1'b0;
            r_op_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (host_req) begin
                        r_host_ack <= 1'b1;
                        r_op       <= host_op;
                        r_rwa      <= host_row;
                        r_nfc_cmd  <= op_to_cmd(host_op);
                        r_count    <= '0;
                        if (host_op == OP_PROG) begin
                            r_wr_ready <= 1'b1;
                            r_bf_sel   <= 1'b1;
                            r_state    <= S_FILL;
                        end else begin
                            r_state    <= S_START;
                        end
                    end
                end

                S_FILL: begin
                    if (wr_valid && r_wr_ready) begin
                        r_bf_we  <= 1'b1;
                        r_bf_din <= wr_data;
                        r_bf_ad  <= r_count[AW-1:0];
                        if (w_last_byte) begin
                            // BF_sel stays up one more cycle so the final
                            // write strobe still reaches the buffer.
                            r_wr_ready <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_count <= w_count_inc;
                        end
                    end
                end

                S_START: begin
                    r_bf_sel   <= 1'b0;
                    r_nfc_strt <= 1'b1;
                    r_tmo      <= '0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    // nfc_done is checked first so it wins over a timeout
                    // landing in the same cycle.
                    if (nfc_done) begin
                        r_op_stat <= {1'b0, RErr, EErr, PErr};
                        if (r_op == OP_READ) begin
                            r_bf_sel   <= 1'b1;
                            r_bf_ad    <= '0;
                            r_count    <= '0;
                            r_rd_phase <= RD_ADDR;
                            r_state    <= S_DRAIN;
                        end else begin
                            r_op_done <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_op_stat <= 4'b1000;
                        r_op_done <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_DRAIN: begin
                    case (r_rd_phase)
                        RD_ADDR: r_rd_phase <= RD_LOAD;
                        RD_LOAD: begin
                            r_rd_data  <= BF_dou;
                            r_rd_valid <= 1'b1;
                            r_rd_phase <= RD_SHOW;
                        end
                        RD_SHOW: begin
                            if (rd_ready) begin
                                r_rd_valid <= 1'b0;
                                if (w_last_byte) begin
                                    r_bf_sel  <= 1'b0;
                                    r_op_done <= 1'b1;
                                    r_state   <= S_RESP;
                                end else begin
                                    r_count    <= w_count_inc;
                                    r_bf_ad    <= w_count_inc[AW-1:0];
                                    r_rd_phase <= RD_ADDR;
                                end
                            end
                        end
                        default: r_rd_phase <= RD_ADDR;
                    endcase
                end

                S_RESP: begin
                    r_bf_sel <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign host_ack = r_host_ack;
    assign wr_ready = r_wr_ready;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign op_done  = r_op_done;
    assign op_stat  = r_op_stat;
    assign BF_sel   = r_bf_sel;
    assign BF_ad    = r_bf_ad;
    assign BF_din   = r_bf_din;
    assign BF_we    = r_bf_we;
    assign RWA      = r_rwa;
    assign nfc_cmd  = r_nfc_cmd;
    assign nfc_strt = r_nfc_strt;

endmodule

// File: tb/tb_nfc_host_seq.sv
// -----------------------------------------------------------------------------
// tb_nfc_host_seq
//   Directed sequence of host operations with randomized flow control,
//   controller latency and error flags. A page-buffer model returns stored
//   bytes one cycle after the address; a controller model answers nfc_strt
//   after a chosen latency (or never, for the timeout case).
// -----------------------------------------------------------------------------
module tb_nfc_host_seq;

    localparam int PAGE   = 2048;
    localparam int TMO    = 64;
    localparam int BUDGET = 30000;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        host_req = 1'b0;
    logic [1:0]  host_op = '0;
    logic [15:0] host_row = '0;
    logic        host_ack;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        op_done;
    logic [3:0]  op_stat;
    logic        BF_sel;
    logic [10:0] BF_ad;
    logic [7:0]  BF_din;
    logic        BF_we;
    logic [7:0]  BF_dou = '0;
    logic [15:0] RWA;
    logic [2:0]  nfc_cmd;
    logic        nfc_strt;
    logic        nfc_done = 1'b0;
    logic        PErr = 1'b0;
    logic        EErr = 1'b0;
    logic        RErr = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] prog_data [PAGE];
    logic [7:0] bf_src    [PAGE];

    nfc_host_seq #(
        .PAGE_BYTES(PAGE),
        .AW        (11),
        .RW        (16),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK      (clk),
        .RES      (res),
        .host_req (host_req),
        .host_op  (host_op),
        .host_row (host_row),
        .host_ack (host_ack),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .op_done  (op_done),
        .op_stat  (op_stat),
        .BF_sel   (BF_sel),
        .BF_ad    (BF_ad),
        .BF_din   (BF_din),
        .BF_we    (BF_we),
        .BF_dou   (BF_dou),
        .RWA      (RWA),
        .nfc_cmd  (nfc_cmd),
        .nfc_strt (nfc_strt),
        .nfc_done (nfc_done),
        .PErr     (PErr),
        .EErr     (EErr),
        .RErr     (RErr)
    );

    always #5 clk = ~clk;

    // Page buffer read port: data for the address seen at an edge appears
    // after that edge.
    always @(posedge clk) BF_dou <= bf_src[BF_ad];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_cmd(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [63:0] out_vec();
        logic [63:0] v;
        v = {7'd0, host_ack, wr_ready, rd_data, rd_valid, op_done, op_stat,
             BF_sel, BF_ad, BF_din, BF_we, RWA, nfc_cmd, nfc_strt};
        return v;
    endfunction

    // Raise a request and wait for its acknowledge. With keep=1 the request
    // stays asserted afterwards (host keeps asking during the operation).
    task automatic issue_req(input logic [1:0] op, input logic [15:0] row, input bit keep);
        bit got = 1'b0;
        @(negedge clk);
        host_req = 1'b1;
        host_op  = op;
        host_row = row;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                check("ack_rwa", 64'(RWA), 64'(row));
                check("ack_cmd", 64'(nfc_cmd), 64'(exp_cmd(op)));
                if (!keep) host_req = 1'b0;
            end
        end
        check("ack_seen", 64'(got), 64'd1);
    endtask

    // Run one accepted operation to completion. lat < 0 means the controller
    // never answers. abort_at >= 0 applies reset after that many program beats.
    task automatic run_body(input logic [1:0] op, input logic [15:0] row, input int lat,
                            input logic [2:0] flags, input int rd_mode, input bit hold_req,
                            input int abort_at);
        int   cycle = 0, writes = 0, wr_idx = 0, rd_idx = 0;
        int   strt_cnt = 0, strt_cycle = -100000, acks = 0, sel_seen = 0;
        bit   done_seen = 1'b0, last_sent = 1'b0;
        bit   is_prog = (op == 2'b01);
        bit   is_read = (op == 2'b00);
        bit   tmo_case = (lat < 0);
        logic [3:0] exp_stat;
        exp_stat = tmo_case ? 4'b1000 : {1'b0, flags};
        host_req = hold_req;
        while (!done_seen && cycle < BUDGET) begin
            @(negedge clk);
            cycle++;
            if (host_ack) acks++;
            if (BF_sel) sel_seen++;
            if (last_sent) begin
                check("wr_ready_drop", 64'(wr_ready), 64'd0);
                last_sent = 1'b0;
            end
            if (BF_we) begin
                check("we_sel", 64'(BF_sel), 64'd1);
                check("prog_ad", 64'(BF_ad), 64'(writes));
                if (writes < PAGE) check("prog_din", 64'(BF_din), 64'(prog_data[writes]));
                writes++;
                if (abort_at >= 0 && writes == abort_at) begin
                    res = 1'b0;
                    wr_valid = 1'b0;
                    @(negedge clk);
                    check("mid_reset_zero", out_vec(), 64'd0);
                    res = 1'b1;
                    return;
                end
            end
            if (nfc_strt) begin
                strt_cnt++;
                strt_cycle = cycle;
                check("strt_cmd", 64'(nfc_cmd), 64'(exp_cmd(op)));
                check("strt_rwa", 64'(RWA), 64'(row));
                check("strt_sel", 64'(BF_sel), 64'd0);
            end
            if (rd_valid) begin
                if (rd_idx < PAGE) check("rd_data", 64'(rd_data), 64'(bf_src[rd_idx]));
                else               check("rd_extra", 64'(rd_valid), 64'd0);
            end
            if (op_done) begin
                done_seen = 1'b1;
                check("op_stat", 64'(op_stat), 64'(exp_stat));
                check("done_cmd", 64'(nfc_cmd), 64'(exp_cmd(op)));
                if (!is_read || tmo_case)
                    check("done_latency", 64'(cycle - strt_cycle),
                          64'(tmo_case ? TMO : lat + 1));
            end

            // host read side
            rd_ready = (rd_mode == 0) ? (((cycle / 3) % 2) == 1) : 1'($urandom_range(0, 1));
            if (rd_valid && rd_ready) rd_idx++;

            // host write side; after a full page keep offering junk bytes
            if (is_prog && wr_idx < PAGE) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_data  = prog_data[wr_idx];
                if (wr_valid && wr_ready) begin
                    wr_idx++;
                    if (wr_idx == PAGE) last_sent = 1'b1;
                end
            end else if (is_prog) begin
                wr_valid = 1'b1;
                wr_data  = 8'hEE;
            end else begin
                wr_valid = 1'b0;
            end

            // controller: flags are noise except in the nfc_done cycle
            if (!tmo_case && strt_cnt > 0 && cycle == strt_cycle + lat) begin
                nfc_done = 1'b1;
                {RErr, EErr, PErr} = flags;
            end else begin
                nfc_done = 1'b0;
                {RErr, EErr, PErr} = 3'($urandom_range(0, 7));
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        nfc_done = 1'b0;
        check("op_done_seen", 64'(done_seen), 64'd1);
        check("strt_count", 64'(strt_cnt), 64'd1);
        check("write_beats", 64'(writes), 64'(is_prog ? PAGE : 0));
        check("read_bytes", 64'(rd_idx), 64'((is_read && !tmo_case) ? PAGE : 0));
        check("no_ack_busy", 64'(acks), 64'd0);
        check("bf_sel_used", 64'(sel_seen != 0), 64'(is_prog || (is_read && !tmo_case)));
    endtask

    initial begin
        int lat;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'd0);
        res = 1'b1;

        // program row 0012 with bytes 0..255 repeating
        for (int i = 0; i < PAGE; i++) prog_data[i] = 8'(i);
        lat = $urandom_range(2, 30);
        issue_req(2'b01, 16'h0012, 1'b0);
        run_body(2'b01, 16'h0012, lat, 3'b000, 1, 1'b0, -1);

        // read row 0034, buffer holds addr[7:0], rd_ready toggles every 3 cycles
        for (int i = 0; i < PAGE; i++) bf_src[i] = 8'(i);
        lat = $urandom_range(2, 30);
        issue_req(2'b00, 16'h0034, 1'b0);
        run_body(2'b00, 16'h0034, lat, 3'b000, 0, 1'b0, -1);

        // read with RErr: random buffer contents, random rd_ready, full drain
        for (int i = 0; i < PAGE; i++) bf_src[i] = 8'($urandom_range(0, 255));
        lat = $urandom_range(2, 30);
        issue_req(2'b00, 16'($urandom_range(0, 65535)), 1'b0);
        run_body(2'b00, host_row, lat, 3'b100, 1, 1'b0, -1);

        // erase row 0100 with EErr, host keeps requesting during WAIT
        lat = $urandom_range(3, 40);
        issue_req(2'b10, 16'h0100, 1'b1);
        run_body(2'b10, 16'h0100, lat, 3'b010, 1, 1'b1, -1);

        // the held request is acknowledged exactly once back in IDLE
        lat = $urandom_range(2, 20);
        issue_req(2'b10, 16'h0100, 1'b0);
        run_body(2'b10, 16'h0100, lat, 3'b001, 1, 1'b0, -1);

        // reset command
        lat = $urandom_range(2, 20);
        issue_req(2'b11, 16'hBEEF, 1'b0);
        run_body(2'b11, 16'hBEEF, lat, 3'b000, 1, 1'b0, -1);

        // read with no nfc_done: timeout, no drain
        issue_req(2'b00, 16'h0777, 1'b0);
        run_body(2'b00, 16'h0777, -1, 3'b000, 1, 1'b0, -1);

        // program interrupted by reset after 100 bytes
        for (int i = 0; i < PAGE; i++) prog_data[i] = 8'($urandom_range(0, 255));
        issue_req(2'b01, 16'h0055, 1'b0);
        run_body(2'b01, 16'h0055, 10, 3'b000, 1, 1'b0, 100);

        // fresh program restarts at address 0
        for (int i = 0; i < PAGE; i++) prog_data[i] = 8'($urandom_range(0, 255));
        lat = $urandom_range(2, 30);
        issue_req(2'b01, 16'h0056, 1'b0);
        run_body(2'b01, 16'h0056, lat, 3'b001, 1, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
